// File: rtl/rf_regfile_p.sv
// ---------------------------------------------------------------------------
// rf_regfile_p
//
// Parametrised register file with 2**AW entries of DW bits each. It has two
// registered read ports (A and B), one write port, a valid bit per entry,
// and a sequenced bulk-clear that sweeps one entry per cycle while busy is
// high.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   : an accepted write forwards din to any read port that reads
//               the same address on the same edge (write-before-read).
//   undefined : read-before-write. A read that hits the address being
//               written returns the old contents.
//
// Ports:
//   clk    in   rising-edge system clock
//   rst    in   asynchronous active-high reset
//   rea    in   read enable, port A
//   raa    in   [AW-1:0] read address, port A
//   reb    in   read enable, port B
//   rab    in   [AW-1:0] read address, port B
//   we     in   write enable (honoured only in IDLE with clr low)
//   wa     in   [AW-1:0] write address
//   din    in   [DW-1:0] write data
//   clr    in   bulk-clear request pulse (ignored while a sweep runs)
//   douta  out  [DW-1:0] registered read data, port A
//   doutb  out  [DW-1:0] registered read data, port B
//   vala   out  valid flag of the entry returned on douta
//   valb   out  valid flag of the entry returned on doutb
//   busy   out  registered, high while the clear sweep runs
// ---------------------------------------------------------------------------
module rf_regfile_p #(
  parameter int DW = 4,
  parameter int AW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rea,
  input  logic [AW-1:0] raa,
  input  logic          reb,
  input  logic [AW-1:0] rab,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [DW-1:0] din,
  input  logic          clr,
  output logic [DW-1:0] douta,
  output logic [DW-1:0] doutb,
  output logic          vala,
  output logic          valb,
  output logic          busy
);

  localparam int DEPTH = 1 << AW;

  // The sweep pointer reaching the all-ones value marks the last entry.
  localparam logic [AW-1:0] PTR_LAST = {AW{1'b1}};

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  // Storage and control state.
  logic [DW-1:0]    mem_q   [DEPTH];
  logic [DW-1:0]    mem_d   [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  state_t           state_q;
  state_t           state_d;
  logic [AW-1:0]    ptr_q;
  logic [AW-1:0]    ptr_d;
  logic             busy_q;
  logic             busy_d;

  // Read port registers.
  logic [DW-1:0]    douta_q;
  logic [DW-1:0]    douta_d;
  logic [DW-1:0]    doutb_q;
  logic [DW-1:0]    doutb_d;
  logic             vala_q;
  logic             vala_d;
  logic             valb_q;
  logic             valb_d;

  // A write is accepted only in IDLE, and a clear request on the same edge
  // takes priority over it.
  logic             wr_acc;

  assign wr_acc = (state_q == IDLE) && we && !clr;

  // Next-state logic: FSM transitions, sweep pointer, writes and clears.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    mem_d   = mem_q;
    valid_d = valid_q;

    case (state_q)
      IDLE: begin
        if (clr) begin
          // Start the sweep. A write on this edge is dropped.
          state_d = CLEAR;
          ptr_d   = {AW{1'b0}};
        end else if (we) begin
          mem_d[wa]   = din;
          valid_d[wa] = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end

      CLEAR: begin
        // One entry is cleared per edge. Writes and further clr pulses are
        // ignored until the sweep finishes.
        mem_d[ptr_q]   = {DW{1'b0}};
        valid_d[ptr_q] = 1'b0;
        ptr_d          = ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (ptr_q == PTR_LAST) begin
          state_d = IDLE;
        end else begin
          state_d = CLEAR;
        end
      end

      default: begin
        state_d = IDLE;
        ptr_d   = {AW{1'b0}};
      end
    endcase

    // busy is high for every cycle the FSM spends in CLEAR.
    busy_d = (state_d == CLEAR);
  end

  // Read ports: one cycle of latency, forced to zero while sweeping.
  always_comb begin
    douta_d = {DW{1'b0}};
    vala_d  = 1'b0;
    doutb_d = {DW{1'b0}};
    valb_d  = 1'b0;

    if (rea && (state_q == IDLE)) begin
      douta_d = mem_q[raa];
      vala_d  = valid_q[raa];
`ifdef RF_BYPASS_EN
      if (wr_acc && (wa == raa)) begin
        douta_d = din;
        vala_d  = 1'b1;
      end else begin
        vala_d  = valid_q[raa];
      end
`endif
    end else begin
      douta_d = {DW{1'b0}};
      vala_d  = 1'b0;
    end

    if (reb && (state_q == IDLE)) begin
      doutb_d = mem_q[rab];
      valb_d  = valid_q[rab];
`ifdef RF_BYPASS_EN
      if (wr_acc && (wa == rab)) begin
        doutb_d = din;
        valb_d  = 1'b1;
      end else begin
        valb_d  = valid_q[rab];
      end
`endif
    end else begin
      doutb_d = {DW{1'b0}};
      valb_d  = 1'b0;
    end
  end

  // Control and read-port registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= {AW{1'b0}};
      busy_q  <= 1'b0;
      valid_q <= {DEPTH{1'b0}};
      douta_q <= {DW{1'b0}};
      doutb_q <= {DW{1'b0}};
      vala_q  <= 1'b0;
      valb_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      douta_q <= douta_d;
      doutb_q <= doutb_d;
      vala_q  <= vala_d;
      valb_q  <= valb_d;
    end
  end

  // Storage array, cleared to zero by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DW{1'b0}};
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign douta = douta_q;
  assign doutb = doutb_q;
  assign vala  = vala_q;
  assign valb  = valb_q;
  assign busy  = busy_q;

endmodule

// File: tb/tb_rf_regfile_p.sv
// ---------------------------------------------------------------------------
// tb_rf_regfile_p
//
// Directed bench for rf_regfile_p (DW=4, AW=2). A table of vectors covers
// reset reads, writes and dual-port reads. Hand-written sequences cover the
// same-address write/read case, the clear sweep with dropped writes and
// ignored clr pulses, the clr/we collision, and an asynchronous reset
// during a sweep.
// ---------------------------------------------------------------------------
module tb_rf_regfile_p;

  logic       clk;
  logic       rst;
  logic       rea;
  logic [1:0] raa;
  logic       reb;
  logic [1:0] rab;
  logic       we;
  logic [1:0] wa;
  logic [3:0] din;
  logic       clr;
  logic [3:0] douta;
  logic [3:0] doutb;
  logic       vala;
  logic       valb;
  logic       busy;

  int total;
  int bad;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  rf_regfile_p #(.DW(4), .AW(2)) dut (
    .clk   (clk),
    .rst   (rst),
    .rea   (rea),
    .raa   (raa),
    .reb   (reb),
    .rab   (rab),
    .we    (we),
    .wa    (wa),
    .din   (din),
    .clr   (clr),
    .douta (douta),
    .doutb (doutb),
    .vala  (vala),
    .valb  (valb),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rea;
    logic [1:0] raa;
    logic       reb;
    logic [1:0] rab;
    logic       we;
    logic [1:0] wa;
    logic [3:0] din;
    logic       clr;
    logic [3:0] ea;
    logic [3:0] eb;
    logic       eva;
    logic       evb;
    logic       ebusy;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] ea, input logic [3:0] eb,
                         input logic eva, input logic evb, input logic ebusy);
    chk({tag, " douta"}, int'(douta), int'(ea));
    chk({tag, " doutb"}, int'(doutb), int'(eb));
    chk({tag, " vala"},  int'(vala),  int'(eva));
    chk({tag, " valb"},  int'(valb),  int'(evb));
    chk({tag, " busy"},  int'(busy),  int'(ebusy));
  endtask

  // Advance one edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    rea = 1'b0; raa = 2'd0; reb = 1'b0; rab = 2'd0;
    we  = 1'b0; wa  = 2'd0; din = 4'h0; clr = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;

    //           rea raa   reb rab   we   wa    din   clr   ea    eb    eva   evb   busy
    vecs[0] = '{1'b1, 2'd0, 1'b1, 2'd1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[1] = '{1'b1, 2'd2, 1'b1, 2'd3, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 2'd2, 1'b0, 2'd2, 1'b1, 2'd2, 4'hA, 1'b0, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 2'd2, 1'b1, 2'd2, 1'b0, 2'd0, 4'h0, 1'b0, 4'hA, 4'hA, 1'b1, 1'b1, 1'b0};
    vecs[4] = '{1'b1, 2'd1, 1'b1, 2'd2, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 4'hA, 1'b0, 1'b1, 1'b0};
    vecs[5] = '{1'b1, 2'd2, 1'b1, 2'd0, 1'b1, 2'd3, 4'h5, 1'b0, 4'hA, 4'h0, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{1'b0, 2'd0, 1'b1, 2'd3, 1'b1, 2'd0, 4'h7, 1'b0, 4'h0, 4'h5, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{1'b1, 2'd0, 1'b1, 2'd3, 1'b1, 2'd1, 4'h9, 1'b0, 4'h7, 4'h5, 1'b1, 1'b1, 1'b0};
    vecs[8] = '{1'b1, 2'd1, 1'b0, 2'd1, 1'b0, 2'd0, 4'h0, 1'b0, 4'h9, 4'h0, 1'b1, 1'b0, 1'b0};

    // Reset state, checked before any clock edge.
    idle_in();
    rst = 1'b1;
    #1;
    chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Table-driven vectors.
    for (int i = 0; i < 9; i++) begin
      rea = vecs[i].rea; raa = vecs[i].raa;
      reb = vecs[i].reb; rab = vecs[i].rab;
      we  = vecs[i].we;  wa  = vecs[i].wa;
      din = vecs[i].din; clr = vecs[i].clr;
      step();
      chk_all($sformatf("vec%0d", i), vecs[i].ea, vecs[i].eb,
              vecs[i].eva, vecs[i].evb, vecs[i].ebusy);
    end

    // Same-cycle write/read of entry 3 (holds 4'h5).
    idle_in();
    we = 1'b1; wa = 2'd3; din = 4'hC; rea = 1'b1; raa = 2'd3;
    step();
    chk("samecyc douta", int'(douta), BYP ? 32'hC : 32'h5);
    chk("samecyc vala", int'(vala), 1);
    idle_in();
    rea = 1'b1; raa = 2'd3;
    step();
    chk("samecyc next douta", int'(douta), 32'hC);

    // Clear sweep. Entries hold 0=7, 1=9, 2=A, 3=C. The clr edge also
    // carries a write of F to entry 0, which must be dropped.
    idle_in();
    clr = 1'b1; we = 1'b1; wa = 2'd0; din = 4'hF; rea = 1'b1; raa = 2'd1;
    step();
    chk("clr edge douta", int'(douta), 32'h9);
    chk("clr edge busy", int'(busy), 1);
    idle_in();
    rea = 1'b1; raa = 2'd1; we = 1'b1; wa = 2'd2; din = 4'h3;
    step();
    chk("sweep1 busy", int'(busy), 1);
    chk("sweep1 douta", int'(douta), 0);
    chk("sweep1 vala", int'(vala), 0);
    idle_in();
    rea = 1'b1; raa = 2'd1; clr = 1'b1;
    step();
    chk("sweep2 busy", int'(busy), 1);
    idle_in();
    step();
    chk("sweep3 busy", int'(busy), 1);
    step();
    chk("sweep4 busy", int'(busy), 0);
    step();
    chk("post sweep busy", int'(busy), 0);
    for (int i = 0; i < 4; i++) begin
      idle_in();
      rea = 1'b1; raa = 2'(i); reb = 1'b1; rab = 2'(3 - i);
      step();
      chk_all($sformatf("cleared%0d", i), 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    end

    // Asynchronous reset during a sweep, with douta still holding data.
    idle_in();
    we = 1'b1; wa = 2'd1; din = 4'h6;
    step();
    idle_in();
    clr = 1'b1; rea = 1'b1; raa = 2'd1; reb = 1'b1; rab = 2'd1;
    step();
    chk_all("pre rst", 4'h6, 4'h6, 1'b1, 1'b1, 1'b1);
    idle_in();
    #2;
    rst = 1'b1;
    #1;
    chk_all("async rst", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    step();
    chk("after rst busy", int'(busy), 0);
    we = 1'b1; wa = 2'd2; din = 4'hB;
    step();
    idle_in();
    rea = 1'b1; raa = 2'd2; reb = 1'b1; rab = 2'd1;
    step();
    chk_all("after rst rd", 4'hB, 4'h0, 1'b1, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
